rf_wr_arbiter: RTL
==================

RF_WR_ARBITER -- requirements
Module: rf_wr_arbiter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, meaning data bits per register.
REQ-002 The block SHALL have parameter DEPTH, default 32, meaning number of registers; legal range 2..1024, power of two not required.
REQ-003 The block SHALL have parameter N_REQ, default 2, meaning number of write requesters; legal range 2..4.
REQ-004 The block SHALL have parameter ZERO_R0, default 1, meaning that when 1, register 0 is read-only zero.
REQ-005 The block SHALL derive constant ADDR_W = clog2(DEPTH).
REQ-006 The block SHALL have port clk, input, 1 bit: the single clock, with all state updating on the rising edge.
REQ-007 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-008 The block SHALL have port i_req_valid, input, N_REQ bits: per-requester write request.
REQ-009 The block SHALL have port i_req_addr, input, N_REQ*ADDR_W bits: packed target addresses, with requester k at slice [k*ADDR_W +: ADDR_W].
REQ-010 The block SHALL have port i_req_data, input, N_REQ*WIDTH bits: packed write data, with requester k at slice [k*WIDTH +: WIDTH].
REQ-011 The block SHALL have port o_req_ready, output, N_REQ bits: per-requester accept, at most one bit high per cycle.
REQ-012 The block SHALL have port o_wr_en, output, 1 bit: register-file write enable.
REQ-013 The block SHALL have port o_wr_addr, output, ADDR_W bits: register-file write address.
REQ-014 The block SHALL have port o_wr_data, output, WIDTH bits: register-file write data.
REQ-015 The block SHALL have port o_busy, output, 1 bit: high while the post-reset clear sequence runs.

Function
REQ-016 The block SHALL implement a two-state FSM, CLEAR and RUN; reset enters CLEAR.
REQ-017 In CLEAR, the block SHALL drive o_wr_en=1, o_wr_addr=clear counter, o_wr_data=0, with the counter stepping 0..DEPTH-1, one register per cycle.
REQ-018 The block SHALL go from CLEAR to RUN on the cycle after address DEPTH-1 is written, so CLEAR lasts exactly DEPTH cycles, then clear the counter to 0.
REQ-019 In CLEAR, the block SHALL hold o_busy=1 and o_req_ready=0; in RUN, o_busy=0.
REQ-020 In RUN, the block SHALL compute o_req_ready combinationally: a one-hot round-robin grant over i_req_valid, or all zeros if no request is valid.
REQ-021 The round-robin pointer SHALL give highest priority to the index after the last granted requester, wrapping from N_REQ-1 to 0; after reset the pointer SHALL be 0, so requester 0 has highest priority.
REQ-022 The pointer SHALL advance only on a completed handshake (valid and ready both high); idle cycles leave it unchanged.
REQ-023 A handshake SHALL register the granted address and data, so that on the next cycle o_wr_en=1 and o_wr_addr/o_wr_data equal the accepted values; write latency is exactly 1 cycle.
REQ-024 With no handshake in RUN, the block SHALL drive o_wr_en=0 the next cycle, and o_wr_addr/o_wr_data SHALL hold their last values.
REQ-025 The block SHALL sustain throughput of one accepted write per cycle, with no bubbles between back-to-back grants.
REQ-026 When ZERO_R0=1, a request to address 0 SHALL complete its handshake normally, but the following cycle SHALL have o_wr_en=0.
REQ-027 When ZERO_R0=0, address 0 SHALL be written like any other address; the CLEAR sequence SHALL always write address 0.
REQ-028 Requesters SHALL hold valid, address and data stable until ready; the block SHALL NOT rely on a requester dropping valid before it is granted.
REQ-029 When multiple requesters target the same address, the block SHALL serialize them in grant order, so the last granted data is what the register holds.

Reset
REQ-030 On a rst=1 edge, outputs SHALL be: o_wr_en=0, o_wr_addr=0, o_wr_data=0, o_busy=1, o_req_ready=0; the FSM SHALL be in CLEAR, the clear counter 0, and the round-robin pointer 0.
REQ-031 Reset asserted mid-CLEAR SHALL restart the clear at address 0; reset asserted in RUN SHALL discard any registered-but-unwritten request, with o_wr_en=0 on the next cycle.

Structure
REQ-032 A shared package rf_pkg SHALL hold the FSM state encoding (CLEAR=0, RUN=1) and the clog2 helper function.
REQ-033 Round-robin grant logic SHALL be a separate sub-module, rr_arbiter, with parameter N, inputs for request vector and pointer, and a one-hot grant output.

Verification
REQ-034 The bench SHALL cover reset: release rst, then o_busy=1 for exactly 32 cycles, with o_wr_addr stepping 0..31 and data 0, and the first ready possible on cycle 33.
REQ-035 The bench SHALL cover fairness: in RUN, hold both valids high, requester 0 at addr 5 with data 0xA5A5A5A5 and requester 1 at addr 6 with data 0x5A5A5A5A; grants SHALL alternate 0,1,0,1, with one write per cycle.
REQ-036 The bench SHALL cover a single requester: only requester 1 valid, 4 consecutive beats; it SHALL be granted every cycle, with o_wr_en=1 for 4 consecutive cycles, each one cycle after its handshake.
REQ-037 The bench SHALL cover the zero register: with ZERO_R0=1, requester 0 writes addr 0 with data 0xFFFFFFFF; ready SHALL be high and o_wr_en SHALL stay 0 the next cycle. Repeat with ZERO_R0=0: o_wr_en SHALL be 1.
REQ-038 The bench SHALL cover reset mid-CLEAR: assert rst at clear addr 17; the counter SHALL restart at 0 and a full 32-cycle clear SHALL follow.
REQ-039 The bench SHALL cover a same-address collision: both requesters target addr 9, requester 0 with data 1 and requester 1 with data 2, with the pointer at 0; writes SHALL be 1 then 2, leaving the final register value 2.

Source files
------------

// File: rtl/rf_pkg.sv
// Shared definitions for the register-file write arbiter: FSM state
// encoding and a constant-evaluable ceiling-log2 helper.
package rf_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_e;

  // Ceiling log2; returns the number of bits needed to index 'value' items.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage : rf_pkg

// File: rtl/rr_arbiter.sv
// One-hot round-robin grant. The requester at index ptr_i has the highest
// priority, priority then descends with wrap-around back to index 0.
module rr_arbiter
  import rf_pkg::*;
#(
  parameter int N     = 2,
  parameter int PTR_W = clog2(N)
) (
  input  logic [N-1:0]     req_i,
  input  logic [PTR_W-1:0] ptr_i,
  output logic [N-1:0]     gnt_o
);

  logic [N-1:0] upper_mask;
  logic [N-1:0] req_upper;
  logic [N-1:0] pick_upper;
  logic [N-1:0] pick_any;

  // Prefer the lowest request at or above the pointer, else wrap to the lowest overall.
  always_comb begin
    // NOTE: every signal written here gets a value on every path; a missing
    // default in combinational logic would infer a latch.
    upper_mask = '0;
    for (int i = 0; i < N; i++) begin
      upper_mask[i] = (i >= int'(ptr_i));
    end
    req_upper  = req_i & upper_mask;
    pick_upper = req_upper & (~req_upper + N'(1));
    pick_any   = req_i & (~req_i + N'(1));
    gnt_o      = (|req_upper) ? pick_upper : pick_any;
  end

endmodule : rr_arbiter

// File: rtl/rf_wr_arbiter.sv
// Register-file write-port arbiter. After reset it zeroes every register,
// one per cycle, then arbitrates N_REQ write requesters round-robin and
// presents the accepted write one cycle after the handshake.
module rf_wr_arbiter
  import rf_pkg::*;
#(
  parameter  int WIDTH   = 32,
  parameter  int DEPTH   = 32,
  parameter  int N_REQ   = 2,
  parameter  bit ZERO_R0 = 1'b1,
  localparam int ADDR_W  = clog2(DEPTH)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          i_req_valid,
  input  logic [N_REQ*ADDR_W-1:0]   i_req_addr,
  input  logic [N_REQ*WIDTH-1:0]    i_req_data,
  output logic [N_REQ-1:0]          o_req_ready,
  output logic                      o_wr_en,
  output logic [ADDR_W-1:0]         o_wr_addr,
  output logic [WIDTH-1:0]          o_wr_data,
  output logic                      o_busy
);

  localparam int PTR_W = clog2(N_REQ);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic [PTR_W-1:0]    ptr_q, ptr_d;
  logic                wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [WIDTH-1:0]    wr_data_q, wr_data_d;

  logic [N_REQ-1:0]    req_run;
  logic [N_REQ-1:0]    gnt;
  logic                handshake;
  logic [ADDR_W-1:0]   sel_addr;
  logic [WIDTH-1:0]    sel_data;
  logic [PTR_W-1:0]    sel_next_ptr;
  logic                clear_active;

  // Requests are only visible to the arbiter once the clear has finished.
  assign req_run   = (state_q == RUN) ? i_req_valid : '0;
  assign handshake = |gnt;

  rr_arbiter #(
    .N     (N_REQ),
    .PTR_W (PTR_W)
  ) u_rr_arbiter (
    .req_i (req_run),
    .ptr_i (ptr_q),
    .gnt_o (gnt)
  );

  // Mux out the granted requester's payload and the pointer that follows it.
  always_comb begin
    sel_addr     = '0;
    sel_data     = '0;
    sel_next_ptr = ptr_q;
    for (int k = 0; k < N_REQ; k++) begin
      if (gnt[k]) begin
        sel_addr     = i_req_addr[k*ADDR_W +: ADDR_W];
        sel_data     = i_req_data[k*WIDTH +: WIDTH];
        sel_next_ptr = (k == N_REQ - 1) ? '0 : PTR_W'(k + 1);
      end
    end
  end

  // Next-state: clear counter sweep in CLEAR, handshake capture in RUN.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ptr_d     = ptr_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    case (state_q)
      CLEAR: begin
        // Track the clear address so RUN starts out holding the last clear write.
        wr_addr_d = cnt_q;
        wr_data_d = '0;
        if (cnt_q == ADDR_W'(DEPTH - 1)) begin
          state_d = RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + ADDR_W'(1);
        end
      end
      RUN: begin
        if (handshake) begin
          ptr_d     = sel_next_ptr;
          wr_addr_d = sel_addr;
          wr_data_d = sel_data;
          // A write to the hardwired-zero register is accepted but dropped.
          wr_en_d   = !(ZERO_R0 && (sel_addr == '0));
        end
      end
      default: state_d = CLEAR;
    endcase
  end

  // State and write-stage registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      state_q   <= CLEAR;
      cnt_q     <= '0;
      ptr_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ptr_q     <= ptr_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  // The clear write is driven straight from the counter; reset masks it.
  assign clear_active = (state_q == CLEAR) && !rst;
  assign o_wr_en      = clear_active | wr_en_q;
  assign o_wr_addr    = clear_active ? cnt_q : wr_addr_q;
  assign o_wr_data    = clear_active ? '0 : wr_data_q;
  assign o_busy       = (state_q == CLEAR);
  assign o_req_ready  = gnt;

endmodule : rf_wr_arbiter
